led_pwm: RTL and testbench

LED_PWM -- requirements
Module: led_pwm

---
 rtl/led_pwm.sv | 145 ++++++++++++++
 tb/tb_led_pwm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm.sv
// Three-channel LED dimmer on a memory-mapped register block. The PWM frame is
// 256 prescaled steps. Blink gating optionally hides whole frames.
module led_pwm #(
    parameter logic [31:0] PWM_BASE = 32'hffff0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data,
    input  logic        led_r_in,
    input  logic        led_g_in,
    input  logic        led_b_in,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b
);

    logic        hit_ctrl, hit_duty, hit_blink, hit_status, hit_any;
    logic        ctrl_wr, tick, frame_end;
    logic [31:0] rd_data;

    logic        enable_q,    enable_d;
    logic        blink_en_q,  blink_en_d;
    logic [7:0]  prescale_q,  prescale_d;
    logic [23:0] duty_q,      duty_d;
    logic [15:0] half_q,      half_d;
    logic [23:0] shadow_q,    shadow_d;
    logic [7:0]  presc_q,     presc_d;
    logic [7:0]  pwm_cnt_q,   pwm_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        phase_q,     phase_d;
    logic        pwm_r_q,     pwm_r_d;
    logic        pwm_g_q,     pwm_g_d;
    logic        pwm_b_q,     pwm_b_d;

    assign hit_ctrl   = (mem_addr == PWM_BASE);
    assign hit_duty   = (mem_addr == PWM_BASE + 32'h4);
    assign hit_blink  = (mem_addr == PWM_BASE + 32'h8);
    assign hit_status = (mem_addr == PWM_BASE + 32'hC);
    assign hit_any    = hit_ctrl | hit_duty | hit_blink | hit_status;

    assign ctrl_wr   = mem_we & hit_ctrl;
    assign tick      = enable_q & (presc_q == prescale_q);
    assign frame_end = tick & (pwm_cnt_q == 8'hFF);

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        rd_data = '0;
        if (hit_ctrl)   rd_data = {16'h0, prescale_q, 6'h0, blink_en_q, enable_q};
        if (hit_duty)   rd_data = {8'h0, duty_q};
        if (hit_blink)  rd_data = {16'h0, half_q};
        if (hit_status) rd_data = {15'h0, phase_q, frame_cnt_q};
    end

    // Bus is released during reset and whenever the master is writing.
    assign mem_data = (rst && !mem_we && hit_any) ? rd_data : 32'bz;

    always_comb begin
        enable_d    = enable_q;
        blink_en_d  = blink_en_q;
        prescale_d  = prescale_q;
        duty_d      = duty_q;
        half_d      = half_q;
        shadow_d    = shadow_q;
        presc_d     = presc_q;
        pwm_cnt_d   = pwm_cnt_q;
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;

        if (ctrl_wr) begin
            enable_d   = mem_data[0];
            blink_en_d = mem_data[1];
            prescale_d = mem_data[15:8];
        end
        if (mem_we && hit_duty)  duty_d = mem_data[23:0];
        if (mem_we && hit_blink) half_d = mem_data[15:0];

        // Pending duty only reaches the comparators between frames or while idle.
        if (frame_end || !enable_q) shadow_d = duty_q;

        if (ctrl_wr || !enable_q) begin
            presc_d     = '0;
            pwm_cnt_d   = '0;
            frame_cnt_d = '0;
            phase_d     = 1'b1;
        end else begin
            presc_d = tick ? 8'h00 : presc_q + 8'd1;
            if (tick) pwm_cnt_d = pwm_cnt_q + 8'd1;
            if (!blink_en_q || half_q == 16'h0) begin
                frame_cnt_d = '0;
                phase_d     = 1'b1;
            end else if (frame_end) begin
                if (frame_cnt_q == half_q - 16'd1) begin
                    frame_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
        end

        pwm_r_d = enable_q & led_r_in & phase_q & (pwm_cnt_q < shadow_q[23:16]);
        pwm_g_d = enable_q & led_g_in & phase_q & (pwm_cnt_q < shadow_q[15:8]);
        pwm_b_d = enable_q & led_b_in & phase_q & (pwm_cnt_q < shadow_q[7:0]);
    end

    // NOTE: state registers use non-blocking assignment so all of them sample the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            enable_q    <= 1'b0;
            blink_en_q  <= 1'b0;
            prescale_q  <= '0;
            duty_q      <= '0;
            half_q      <= '0;
            shadow_q    <= '0;
            presc_q     <= '0;
            pwm_cnt_q   <= '0;
            frame_cnt_q <= '0;
            phase_q     <= 1'b1;
            pwm_r_q     <= 1'b0;
            pwm_g_q     <= 1'b0;
            pwm_b_q     <= 1'b0;
        end else begin
            enable_q    <= enable_d;
            blink_en_q  <= blink_en_d;
            prescale_q  <= prescale_d;
            duty_q      <= duty_d;
            half_q      <= half_d;
            shadow_q    <= shadow_d;
            presc_q     <= presc_d;
            pwm_cnt_q   <= pwm_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            pwm_r_q     <= pwm_r_d;
            pwm_g_q     <= pwm_g_d;
            pwm_b_q     <= pwm_b_d;
        end
    end

    assign pwm_r = pwm_r_q;
    assign pwm_g = pwm_g_q;
    assign pwm_b = pwm_b_q;

endmodule

// File: tb/tb_led_pwm.sv
// Directed bench for led_pwm: register access, duty/prescale timing, shadowing,
// blink gating, channel gates and mid-frame reset.
module tb_led_pwm;

    localparam logic [31:0] A_CTRL   = 32'hffff0010;
    localparam logic [31:0] A_DUTY   = 32'hffff0014;
    localparam logic [31:0] A_BLINK  = 32'hffff0018;
    localparam logic [31:0] A_STATUS = 32'hffff001C;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [31:0] mem_addr;
    wire  [31:0] mem_data;
    logic [31:0] tb_drv;
    logic        tb_oe;
    logic        led_r_in, led_g_in, led_b_in;
    logic        pwm_r, pwm_g, pwm_b;

    int pass_cnt = 0;
    int total_cnt = 0;

    assign mem_data = tb_oe ? tb_drv : 32'bz;

    always #5 clk = ~clk;

    led_pwm #(.PWM_BASE(32'hffff0010)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .led_r_in (led_r_in),
        .led_g_in (led_g_in),
        .led_b_in (led_b_in),
        .pwm_r    (pwm_r),
        .pwm_g    (pwm_g),
        .pwm_b    (pwm_b)
    );

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        mem_we = 1'b1; mem_addr = addr; tb_drv = data; tb_oe = 1'b1;
        @(negedge clk);
        mem_we = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        mem_we = 1'b0; tb_oe = 1'b0; mem_addr = addr;
        #1;
        data = mem_data;
    endtask

    task automatic expect_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] got;
        bus_read(addr, got);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else pass_cnt++;
    endtask

    task automatic expect_int(input string name, input int got, input int exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        rst = 1'b0; mem_we = 1'b0; mem_addr = '0; tb_drv = '0; tb_oe = 1'b0;
        led_r_in = 1'b1; led_g_in = 1'b1; led_b_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_read("reset_ctrl",   A_CTRL,   32'h0);
        expect_read("reset_duty",   A_DUTY,   32'h0);
        expect_read("reset_blink",  A_BLINK,  32'h0);
        expect_read("reset_status", A_STATUS, 32'h0001_0000);
        expect_int("reset_pwm", {pwm_r, pwm_g, pwm_b}, 0);
    endtask

    task automatic test_regs;
        bus_write(32'hffff0011, 32'h0000_0301);
        bus_write(32'hffff0020, 32'h0000_0301);
        expect_read("ignored_addr_ctrl", A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'hFFFF_FFFF);
        expect_read("status_read_only", A_STATUS, 32'h0001_0000);
        bus_write(A_CTRL, 32'hFFFF_FFFF);
        expect_read("ctrl_unused_bits", A_CTRL, 32'h0000_FF03);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_DUTY, 32'hFFFF_FFFF);
        expect_read("duty_unused_bits", A_DUTY, 32'h00FF_FFFF);
        bus_write(A_BLINK, 32'hFFFF_FFFF);
        expect_read("blink_unused_bits", A_BLINK, 32'h0000_FFFF);
        bus_write(A_BLINK, 32'h0);
        bus_write(A_DUTY, 32'h0);
    endtask

    task automatic test_duty_prescale0;
        int nr, ng, nb;
        nr = 0; ng = 0; nb = 0;
        bus_write(A_DUTY, 32'h0080_4000);
        bus_write(A_CTRL, 32'h0000_0001);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            nr += int'(pwm_r); ng += int'(pwm_g); nb += int'(pwm_b);
        end
        expect_int("p0_r_high", nr, 128);
        expect_int("p0_g_high", ng, 64);
        expect_int("p0_b_high", nb, 0);
    endtask

    task automatic test_prescale3;
        int lows, ng;
        lows = 0; ng = 0;
        bus_write(A_CTRL, 32'h0000_0301);
        bus_write(A_DUTY, 32'h00FF_0000);
        repeat (1100) @(negedge clk);
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            lows += int'(!pwm_r); ng += int'(pwm_g);
        end
        expect_int("p3_r_low", lows, 4);
        expect_int("p3_g_high", ng, 0);
    endtask

    task automatic test_duty_rewrite;
        int f1, f2;
        logic [31:0] rd;
        f1 = 0; f2 = 0;
        bus_write(A_CTRL, 32'h0);
        bus_write(A_DUTY, 32'h0010_0000);
        @(negedge clk);
        bus_write(A_CTRL, 32'h0000_0001);
        for (int i = 1; i <= 512; i++) begin
            if (i == 50) begin
                mem_we = 1'b1; mem_addr = A_DUTY; tb_drv = 32'h00F0_0000; tb_oe = 1'b1;
            end else if (i == 51) begin
                mem_we = 1'b0; tb_oe = 1'b0;
            end else if (i == 100) begin
                bus_read(A_DUTY, rd);
                total_cnt++;
                if (rd !== 32'h00F0_0000) $display("FAIL duty_pending_read: got %h expected %h", rd, 32'h00F0_0000);
                else pass_cnt++;
            end
            @(negedge clk);
            if (i <= 256) f1 += int'(pwm_r);
            else          f2 += int'(pwm_r);
        end
        expect_int("rewrite_frame_cur", f1, 16);
        expect_int("rewrite_frame_next", f2, 240);
    endtask

    task automatic test_blink;
        int f1, f3, f5;
        f1 = 0; f3 = 0; f5 = 0;
        bus_write(A_CTRL, 32'h0);
        bus_write(A_DUTY, 32'h00FF_0000);
        bus_write(A_BLINK, 32'h0000_0002);
        bus_write(A_CTRL, 32'h0000_0003);
        mem_addr = A_STATUS;
        for (int i = 1; i <= 1280; i++) begin
            @(negedge clk);
            if (i <= 256)                f1 += int'(pwm_r);
            else if (i > 512 && i <= 768) f3 += int'(pwm_r);
            else if (i > 1024)           f5 += int'(pwm_r);
            if (i == 300)  expect_read("blink_status_f2", A_STATUS, 32'h0001_0001);
            if (i == 600)  expect_read("blink_status_f3", A_STATUS, 32'h0000_0000);
            if (i == 900)  expect_read("blink_status_f4", A_STATUS, 32'h0000_0001);
            if (i == 1100) expect_read("blink_status_f5", A_STATUS, 32'h0001_0000);
        end
        expect_int("blink_on_f1", f1, 255);
        expect_int("blink_off_f3", f3, 0);
        expect_int("blink_on_f5", f5, 255);
    endtask

    task automatic test_gate_and_reset;
        logic [31:0] rd;
        int highs;
        bus_write(A_CTRL, 32'h0);
        bus_write(A_BLINK, 32'h0);
        bus_write(A_DUTY, 32'h00FF_FFFF);
        bus_write(A_CTRL, 32'h0000_0001);
        repeat (10) @(negedge clk);
        expect_int("gate_g_before", int'(pwm_g), 1);
        led_g_in = 1'b0;
        @(negedge clk);
        expect_int("gate_g_dropped", int'(pwm_g), 0);
        expect_int("gate_r_kept", int'(pwm_r), 1);
        led_g_in = 1'b1;
        repeat (5) @(negedge clk);

        mem_addr = A_CTRL;
        rst = 1'b0;
        #1;
        rd = mem_data;
        total_cnt++;
        if (rd === 32'h0000_0001) $display("FAIL rst_bus_released: got %h expected high-Z", rd);
        else pass_cnt++;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            highs += int'(pwm_r) + int'(pwm_g) + int'(pwm_b);
        end
        expect_int("rst_no_pulse", highs, 0);
        bus_read(A_STATUS, rd);
        total_cnt++;
        if (rd === 32'h0001_0000) $display("FAIL rst_status_released: got %h expected high-Z", rd);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        expect_read("post_rst_ctrl",   A_CTRL,   32'h0);
        expect_read("post_rst_duty",   A_DUTY,   32'h0);
        expect_read("post_rst_status", A_STATUS, 32'h0001_0000);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            highs += int'(pwm_r) + int'(pwm_g) + int'(pwm_b);
        end
        expect_int("post_rst_pwm_idle", highs, 0);
    endtask

    initial begin
        test_reset();
        test_regs();
        test_duty_prescale0();
        test_prescale3();
        test_duty_rewrite();
        test_blink();
        test_gate_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
